dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-port, word-addressed data memory. It sits between the core load/store unit (requester 0) and a secondary master such as DMA or debug (requester 1). It grants the memory to one requester at a time with round-robin fairness and drives the memory's WE/A/WD pins for exactly one cycle per transaction. It returns registered read data, or an error, to the winning requester.

## Interface
- MEM_BYTES, 65536: byte size of the attached memory; the legal word addresses are 0 to MEM_BYTES-4.
- clk  in  1  rising-edge clock shared with the data memory.
- rst_n  in  1  asynchronous, active-low reset.
- m0_valid  in  1  requester 0 has a request pending.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  32  byte address; must be word-aligned.
- m0_wdata  in  32  write data.
- m0_ready  out  1  request accepted this cycle (combinational).
- m0_rvalid  out  1  one-cycle completion pulse.
- m0_rdata  out  32  read data, valid while m0_rvalid is high.
- m0_err  out  1  completion carries an error, valid while m0_rvalid is high.
- m1_valid, m1_we, m1_addr, m1_wdata, m1_ready, m1_rvalid, m1_rdata, m1_err: same directions, widths and meanings for requester 1.
- mem_we  out  1  memory write enable.
- mem_a  out  32  memory address.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_a.

## Operation
- FSM has two states, IDLE and ACCESS; reset state is IDLE.
- **IDLE, acceptance:**
  - If any mX_valid is high, the winner's mX_ready is high and the request is latched at the clock edge. The FSM then moves to ACCESS.
  - The loser's ready stays low.
  - Requesters must hold valid and payload stable until ready.
- **Arbitration:**
  - `last_grant` register, reset value 1, so requester 0 wins the first conflict.
  - When both requesters are valid, the winner is the requester that is not `last_grant`.
  - When only one requester is valid, it wins.
  - `last_grant` updates only on acceptance.
- **Error check at acceptance:** a request is in error if addr[1:0] != 0 or addr > MEM_BYTES-4.
- **ACCESS:**
  - mem_a = latched addr.
  - mem_wd = latched wdata.
  - mem_we = latched we AND NOT error.
  - At the end of the cycle:
    - The write commits in memory.
    - mem_rd is captured into the response register; 0 is captured instead for writes and errored requests.
    - The FSM returns to IDLE.
- **Response:**
  - In the cycle after ACCESS, the winner's mX_rvalid is high for exactly one cycle, with mX_rdata and mX_err driven.
  - In that same cycle the FSM is in IDLE and may accept a new request.
- **Outputs outside ACCESS:**
  - mem_we = 0.
  - mem_a and mem_wd hold their last latched values; their reset value is 0.
- Errored requests still occupy the ACCESS cycle, so timing is uniform, but never write memory.

## Timing
- Accept edge at the end of cycle N.
- ACCESS in cycle N+1.
- rvalid in cycle N+2.
- Peak throughput is 1 transaction per 2 cycles.
- mX_ready is combinational from valid, state and `last_grant`. It is never high in ACCESS.
- **Reset values:**
  - All ready, rvalid, err and mem_we outputs are 0.
  - rdata, mem_a and mem_wd are 0.
  - `last_grant` is 1.
- **Reset asserted mid-ACCESS:**
  - mem_we drops to 0 immediately (asynchronously), so no write commits on the next edge.
  - No rvalid is issued for the aborted transaction.
- A valid that drops before ready is legal and is simply not serviced.
- A requester re-issuing valid in its own rvalid cycle competes normally in arbitration.

## Test plan
- **Single read:** memory word at 0x10 = 0xDEADBEEF; m0 reads 0x10 → m0_ready in cycle 0, mem_we=0 and mem_a=0x10 in cycle 1, m0_rvalid=1 with m0_rdata=0xDEADBEEF and m0_err=0 in cycle 2.
- **Write then read:**
  - m1 writes 0x12345678 to 0x20: mem_we=1 for exactly one cycle, m1_rvalid with err=0 and rdata=0.
  - m1 then reads 0x20: returns 0x12345678.
- **Conflict and fairness:** m0 and m1 hold valid continuously after reset → grants alternate 0,1,0,1, one acceptance every 2 cycles, with no back-to-back ready on the same port while both are waiting.
- **Errors:**
  - Write to 0x22 (misaligned) → m0_err=1, mem_we never asserted, memory word 0x20 unchanged.
  - Read at 0xFFFD with MEM_BYTES=65536 (out of range) → m0_err=1, m0_rdata=0.
- **Reset mid-ACCESS:** rst_n pulsed low during the ACCESS cycle of a write of 0xAAAAAAAA to 0x30 → mem_we=0 at once, no rvalid, word 0x30 keeps its old value, and the next conflict is won by m0.
- **Response overlapped with acceptance:** m0 raises valid again in its own rvalid cycle → m0_ready is high in that same cycle, and the next rvalid comes 2 cycles later.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port, word-addressed data memory.
// One request is accepted in IDLE, the memory is driven for one ACCESS cycle, and the response is registered.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] ADDR_MAX = AW'(MEM_BYTES - 4);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic          last_grant;
    logic          sel;
    logic          lat_we;
    logic          lat_err;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          win;
    logic          win_we;
    logic          win_err;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic [DW-1:0] resp_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and grants; on a conflict the requester that did not win last time is served
    always_comb begin
        next_state = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                grant0 = m0_valid && (!m1_valid || last_grant);
                grant1 = m1_valid && (!m0_valid || !last_grant);
                if (grant0 || grant1) begin
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign m0_ready = grant0;
    assign m1_ready = grant1;
    assign accept   = grant0 | grant1;
    assign win      = grant1;

    assign win_we    = win ? m1_we    : m0_we;
    assign win_addr  = win ? m1_addr  : m0_addr;
    assign win_wdata = win ? m1_wdata : m0_wdata;
    assign win_err   = (win_addr[1:0] != 2'b00) || (win_addr > ADDR_MAX);

    // Request latch; mem_we is a flop so reset kills a pending write immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            sel        <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                last_grant <= win;
                sel        <= win;
                lat_we     <= win_we;
                lat_err    <= win_err;
                mem_we     <= win_we & ~win_err;
                mem_a      <= win_addr;
                mem_wd     <= win_wdata;
            end
        end
    end

    assign resp_data = (lat_we || lat_err) ? '0 : mem_rd;

    // Response registers, loaded at the end of ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            if (state == ACCESS) begin
                if (sel) begin
                    m1_rvalid <= 1'b1;
                    m1_rdata  <= resp_data;
                    m1_err    <= lat_err;
                end else begin
                    m0_rvalid <= 1'b1;
                    m0_rdata  <= resp_data;
                    m0_err    <= lat_err;
                end
            end
        end
    end

endmodule
